// File: rtl/pixel_rect_printer_pkg.sv
// Shared video definitions for the rectangle printer: frame defaults, bus widths, FSM encoding
// and a shift-add helper for scaling a row index by the frame width.
package pixel_rect_printer_pkg;

  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  localparam int ADDR_W    = 19;
  localparam int COLOR_W   = 9;
  localparam int X_W       = 10;
  localparam int Y_W       = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRINT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // y * k built from shifted copies of y, one per set bit of the constant k
  function automatic logic [ADDR_W-1:0] row_offset(input logic [Y_W-1:0] y, input int k);
    logic [ADDR_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (k[i]) acc = acc + (ADDR_W'(y) << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/pixel_rect_printer_if.sv
// Command handshake, framebuffer write port and status lines of the rectangle printer.
// master = command source / framebuffer side, slave = printer.
interface pixel_rect_printer_if;
  import pixel_rect_printer_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [X_W-1:0]     cmd_x;
  logic [Y_W-1:0]     cmd_y;
  logic [X_W-1:0]     cmd_w;
  logic [Y_W-1:0]     cmd_h;
  logic [COLOR_W-1:0] cmd_color;
  logic               mem_wr_en;
  logic [ADDR_W-1:0]  mem_addr;
  logic [COLOR_W-1:0] mem_wdata;
  logic               mem_wait;
  logic               is_printing;
  logic               done_pulse;

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, mem_wait,
    input  cmd_ready, mem_wr_en, mem_addr, mem_wdata, is_printing, done_pulse
  );

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, mem_wait,
    output cmd_ready, mem_wr_en, mem_addr, mem_wdata, is_printing, done_pulse
  );

endinterface

// File: rtl/pixel_rect_printer_rect_clip.sv
// Combinational clip of a rectangle to the frame; sums are one bit wider than the operands
// so large x+w or y+h saturate at the frame edge instead of wrapping.
module rect_clip
  import pixel_rect_printer_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic [X_W-1:0] cmd_x,
  input  logic [Y_W-1:0] cmd_y,
  input  logic [X_W-1:0] cmd_w,
  input  logic [Y_W-1:0] cmd_h,
  output logic [X_W:0]   x_end,
  output logic [Y_W:0]   y_end,
  output logic           empty
);

  localparam logic [X_W:0] H_LIM = (X_W+1)'(H_RES);
  localparam logic [Y_W:0] V_LIM = (Y_W+1)'(V_RES);

  logic [X_W:0] x_sum;
  logic [Y_W:0] y_sum;

  assign x_sum = {1'b0, cmd_x} + {1'b0, cmd_w};
  assign y_sum = {1'b0, cmd_y} + {1'b0, cmd_h};

  assign x_end = (x_sum > H_LIM) ? H_LIM : x_sum;
  assign y_end = (y_sum > V_LIM) ? V_LIM : y_sum;

  // Covers zero width/height as well as an origin at or beyond the frame edge
  assign empty = (x_end <= {1'b0, cmd_x}) || (y_end <= {1'b0, cmd_y});

endmodule

// File: rtl/pixel_rect_printer.sv
// Fills a clipped rectangle in the framebuffer, one pixel per cycle in raster order; first write
// the cycle after acceptance. mem_wait freezes the write port; commands are only taken while idle.
module pixel_rect_printer
  import pixel_rect_printer_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  pixel_rect_printer_if.slave bus
);

  state_t            state;
  logic [X_W-1:0]    x_start;
  logic [X_W:0]      x_cur;
  logic [X_W:0]      x_end;
  logic [Y_W:0]      y_cur;
  logic [Y_W:0]      y_end;
  logic [ADDR_W-1:0] row_base;

  logic [X_W:0]      clip_x_end;
  logic [Y_W:0]      clip_y_end;
  logic              clip_empty;
  logic [ADDR_W-1:0] first_base;
  logic              write_done;
  logic              last_col;
  logic              last_row;

  rect_clip #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_rect_clip (
    .cmd_x (bus.cmd_x),
    .cmd_y (bus.cmd_y),
    .cmd_w (bus.cmd_w),
    .cmd_h (bus.cmd_h),
    .x_end (clip_x_end),
    .y_end (clip_y_end),
    .empty (clip_empty)
  );

  assign first_base = row_offset(bus.cmd_y, H_RES);
  assign write_done = bus.mem_wr_en && !bus.mem_wait;
  assign last_col   = (x_cur + 1'b1) == x_end;
  assign last_row   = (y_cur + 1'b1) == y_end;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      bus.cmd_ready   <= 1'b1;
      bus.mem_wr_en   <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.is_printing <= 1'b0;
      bus.done_pulse  <= 1'b0;
      x_start         <= '0;
      x_cur           <= '0;
      x_end           <= '0;
      y_cur           <= '0;
      y_end           <= '0;
      row_base        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.cmd_ready   <= 1'b0;
            bus.is_printing <= 1'b1;
            if (clip_empty) begin
              state          <= DONE;
              bus.done_pulse <= 1'b1;
            end else begin
              state         <= PRINT;
              bus.mem_wr_en <= 1'b1;
              bus.mem_addr  <= first_base + ADDR_W'(bus.cmd_x);
              bus.mem_wdata <= bus.cmd_color;
              row_base      <= first_base;
              x_start       <= bus.cmd_x;
              x_cur         <= {1'b0, bus.cmd_x};
              x_end         <= clip_x_end;
              y_cur         <= {1'b0, bus.cmd_y};
              y_end         <= clip_y_end;
            end
          end
        end

        PRINT: begin
          if (write_done) begin
            if (!last_col) begin
              x_cur        <= x_cur + 1'b1;
              bus.mem_addr <= bus.mem_addr + 1'b1;
            end else if (!last_row) begin
              // Row change computes the next address directly so no bubble is inserted
              row_base     <= row_base + ADDR_W'(H_RES);
              y_cur        <= y_cur + 1'b1;
              x_cur        <= {1'b0, x_start};
              bus.mem_addr <= row_base + ADDR_W'(H_RES) + ADDR_W'(x_start);
            end else begin
              state          <= DONE;
              bus.mem_wr_en  <= 1'b0;
              bus.done_pulse <= 1'b1;
            end
          end
        end

        DONE: begin
          state           <= IDLE;
          bus.done_pulse  <= 1'b0;
          bus.is_printing <= 1'b0;
          bus.cmd_ready   <= 1'b1;
        end

        default: begin
          state           <= IDLE;
          bus.cmd_ready   <= 1'b1;
          bus.mem_wr_en   <= 1'b0;
          bus.is_printing <= 1'b0;
          bus.done_pulse  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_rect_printer.sv
// Directed bench for pixel_rect_printer: expected writes are queued at issue time and a
// negedge monitor pops and compares every completed framebuffer write.
module tb_pixel_rect_printer;
  import pixel_rect_printer_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pixel_rect_printer_if bus();

  pixel_rect_printer #(
    .H_RES (640),
    .V_RES (480)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int exp_addr[$];
  int exp_data[$];
  int wr_cyc_q[$];
  int done_total = 0;
  int busy_total = 0;
  int wr_hi_total = 0;
  int last_done_cyc = -1;
  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [COLOR_W-1:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    int a;
    int d;
    if (prev_stall) begin
      check("stall_hold_wr_en", int'(bus.mem_wr_en), 1);
      check("stall_hold_addr", int'(bus.mem_addr), int'(prev_addr));
      check("stall_hold_data", int'(bus.mem_wdata), int'(prev_data));
    end
    prev_stall = bus.mem_wr_en && bus.mem_wait;
    prev_addr  = bus.mem_addr;
    prev_data  = bus.mem_wdata;
    if (bus.mem_wr_en) wr_hi_total++;
    if (bus.is_printing) busy_total++;
    if (bus.done_pulse) begin
      done_total++;
      last_done_cyc = cyc;
    end
    if (bus.mem_wr_en && !bus.mem_wait) begin
      wr_cyc_q.push_back(cyc);
      if (exp_addr.size() == 0) begin
        check("unexpected_write_addr", int'(bus.mem_addr), -1);
      end else begin
        a = exp_addr.pop_front();
        d = exp_data.pop_front();
        check("write_addr", int'(bus.mem_addr), a);
        check("write_data", int'(bus.mem_wdata), d);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int a, input int d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  // Holds cmd_valid until the printer is seen ready, returns the first cycle after acceptance
  task automatic issue(input logic [9:0] x, input logic [8:0] y, input logic [9:0] w,
                       input logic [8:0] h, input logic [8:0] c, output int acc);
    bus.cmd_x = x;
    bus.cmd_y = y;
    bus.cmd_w = w;
    bus.cmd_h = h;
    bus.cmd_color = c;
    bus.cmd_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        @(posedge clk);
        #1;
        acc = cyc;
        break;
      end
    end
    bus.cmd_valid = 1'b0;
    if (acc < 0) check("accept_timeout_ready", int'(bus.cmd_ready), 1);
  endtask

  task automatic wait_done(input int budget, input int start);
    for (int i = 0; i < budget; i++) begin
      if (done_total > start) break;
      @(negedge clk);
      #1;
    end
    check("done_count", done_total - start, 1);
    tick(1);
  endtask

  function automatic int first_wr();
    return (wr_cyc_q.size() > 0) ? wr_cyc_q[0] : -1;
  endfunction

  function automatic int last_wr();
    return (wr_cyc_q.size() > 0) ? wr_cyc_q[$] : -1;
  endfunction

  initial begin
    int acc;
    int acc_b;
    int b0;
    int d0;
    int h0;
    int done_a;

    bus.cmd_valid = 1'b0;
    bus.cmd_x = '0;
    bus.cmd_y = '0;
    bus.cmd_w = '0;
    bus.cmd_h = '0;
    bus.cmd_color = '0;
    bus.mem_wait = 1'b0;

    tick(3);
    check("rst_cmd_ready", int'(bus.cmd_ready), 1);
    check("rst_mem_wr_en", int'(bus.mem_wr_en), 0);
    check("rst_is_printing", int'(bus.is_printing), 0);
    check("rst_done_pulse", int'(bus.done_pulse), 0);
    check("rst_mem_addr", int'(bus.mem_addr), 0);
    check("rst_mem_wdata", int'(bus.mem_wdata), 0);
    reset_n = 1'b1;
    tick(2);

    // 3x2 at (10,20), no stalls
    foreach (wr_cyc_q[i]) wr_cyc_q.delete();
    wr_cyc_q.delete();
    push_exp(12810, 511); push_exp(12811, 511); push_exp(12812, 511);
    push_exp(13450, 511); push_exp(13451, 511); push_exp(13452, 511);
    b0 = busy_total; d0 = done_total;
    issue(10'd10, 9'd20, 10'd3, 9'd2, 9'h1FF, acc);
    wait_done(40, d0);
    check("t1_write_count", wr_cyc_q.size(), 6);
    check("t1_first_write_cycle", first_wr(), acc);
    check("t1_last_write_cycle", last_wr(), acc + 5);
    check("t1_done_cycle", last_done_cyc, acc + 6);
    check("t1_busy_cycles", busy_total - b0, 7);

    // Same rectangle, 4-cycle stall on the second write
    wr_cyc_q.delete();
    push_exp(12810, 511); push_exp(12811, 511); push_exp(12812, 511);
    push_exp(13450, 511); push_exp(13451, 511); push_exp(13452, 511);
    b0 = busy_total; d0 = done_total; h0 = wr_hi_total;
    issue(10'd10, 9'd20, 10'd3, 9'd2, 9'h1FF, acc);
    tick(1);
    bus.mem_wait = 1'b1;
    tick(4);
    bus.mem_wait = 1'b0;
    wait_done(40, d0);
    check("t2_write_count", wr_cyc_q.size(), 6);
    check("t2_wr_en_cycles", wr_hi_total - h0, 10);
    check("t2_busy_cycles", busy_total - b0, 11);
    check("t2_done_cycle", last_done_cyc, acc + 10);

    // Bottom-right corner, clipped to two pixels
    wr_cyc_q.delete();
    push_exp(307198, 165); push_exp(307199, 165);
    d0 = done_total;
    issue(10'd638, 9'd479, 10'd5, 9'd4, 9'h0A5, acc);
    wait_done(40, d0);
    check("t3_write_count", wr_cyc_q.size(), 2);
    check("t3_done_cycle", last_done_cyc, acc + 2);

    // Zero width: straight to DONE
    wr_cyc_q.delete();
    b0 = busy_total; d0 = done_total; h0 = wr_hi_total;
    issue(10'd5, 9'd5, 10'd0, 9'd3, 9'h111, acc);
    wait_done(20, d0);
    check("t4_wr_en_cycles", wr_hi_total - h0, 0);
    check("t4_busy_cycles", busy_total - b0, 1);
    check("t4_done_cycle", last_done_cyc, acc);

    // Origin beyond the right edge
    b0 = busy_total; d0 = done_total; h0 = wr_hi_total;
    issue(10'd700, 9'd5, 10'd4, 9'd2, 9'h111, acc);
    wait_done(20, d0);
    check("t5_wr_en_cycles", wr_hi_total - h0, 0);
    check("t5_busy_cycles", busy_total - b0, 1);
    check("t5_done_cycle", last_done_cyc, acc);

    // Command while busy is ignored; the next one is taken right after DONE
    wr_cyc_q.delete();
    push_exp(12810, 28); push_exp(12811, 28); push_exp(12812, 28);
    push_exp(13450, 28); push_exp(13451, 28); push_exp(13452, 28);
    push_exp(640, 341); push_exp(641, 341);
    d0 = done_total;
    issue(10'd10, 9'd20, 10'd3, 9'd2, 9'h01C, acc);
    bus.cmd_x = 10'd100; bus.cmd_y = 9'd100; bus.cmd_w = 10'd1; bus.cmd_h = 9'd1;
    bus.cmd_color = 9'h007;
    bus.cmd_valid = 1'b1;
    tick(3);
    bus.cmd_valid = 1'b0;
    tick(1);
    issue(10'd0, 9'd1, 10'd2, 9'd1, 9'h155, acc_b);
    done_a = last_done_cyc;
    check("t6_done_first", done_total - d0, 1);
    check("t6_done_a_cycle", done_a, acc + 6);
    check("t6_back_to_back_gap", acc_b - done_a, 2);
    wait_done(40, done_total);
    check("t6_write_count", wr_cyc_q.size(), 8);
    check("t6_b_first_write", (wr_cyc_q.size() > 6) ? wr_cyc_q[6] : -1, acc_b);

    // Reset in the middle of a 4x4 fill
    wr_cyc_q.delete();
    push_exp(0, 240); push_exp(1, 240);
    d0 = done_total;
    issue(10'd0, 9'd0, 10'd4, 9'd4, 9'h0F0, acc);
    for (int i = 0; i < 20; i++) begin
      if (wr_cyc_q.size() >= 2) break;
      @(negedge clk);
      #1;
    end
    reset_n = 1'b0;
    tick(1);
    check("t7_wr_en_after_reset", int'(bus.mem_wr_en), 0);
    check("t7_busy_after_reset", int'(bus.is_printing), 0);
    check("t7_ready_after_reset", int'(bus.cmd_ready), 1);
    check("t7_done_after_reset", int'(bus.done_pulse), 0);
    reset_n = 1'b1;
    tick(10);
    check("t7_no_done_pulse", done_total - d0, 0);
    check("t7_write_count", wr_cyc_q.size(), 2);

    check("scoreboard_drained", exp_addr.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_rect_printer.md
PIXEL_RECT_PRINTER -- requirements
Module: pixel_rect_printer

Interface
REQ-001 Parameter H_RES, default 640, frame width in pixels.
REQ-002 Parameter V_RES, default 480, frame height in pixels.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 cmd_valid  input  1  print command present.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_x  input  10  rectangle left column.
REQ-008 cmd_y  input  9  rectangle top row.
REQ-009 cmd_w  input  10  rectangle width in pixels.
REQ-010 cmd_h  input  9  rectangle height in pixels.
REQ-011 cmd_color  input  9  RGB 3-3-3 fill colour.
REQ-012 mem_wr_en  output  1  framebuffer write request.
REQ-013 mem_addr  output  19  framebuffer word address, y*H_RES + x.
REQ-014 mem_wdata  output  9  pixel colour to write.
REQ-015 mem_wait  input  1  framebuffer stall; write is not taken while high.
REQ-016 is_printing  output  1  busy flag driving the processor-readable 1-bit status input port.
REQ-017 done_pulse  output  1  one-cycle end-of-command strobe.

Function
REQ-018 The block SHALL use FSM states IDLE, PRINT, DONE; all outputs registered.
REQ-019 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a cycle with cmd_valid=1 and cmd_ready=1, capturing all cmd_* fields.
REQ-020 On acceptance, the block SHALL clip the rectangle: x_end = min(cmd_x+cmd_w, H_RES), y_end = min(cmd_y+cmd_h, V_RES), using 11-bit/10-bit sums so no overflow wraps.
REQ-021 If the clipped width or height is 0 (including cmd_x>=H_RES or cmd_y>=V_RES), the block SHALL go IDLE->DONE without any write.
REQ-022 Otherwise IDLE->PRINT; mem_wr_en SHALL rise the cycle after acceptance with the first pixel (cmd_x, cmd_y).
REQ-023 Pixels SHALL be written in raster order, x inner, y outer, exactly once each.
REQ-024 A write SHALL complete on a cycle with mem_wr_en=1 and mem_wait=0; while mem_wait=1, mem_wr_en, mem_addr, mem_wdata SHALL hold stable.
REQ-025 With mem_wait held 0, throughput SHALL be one pixel per cycle, including across row changes.
REQ-026 mem_addr SHALL be formed from a row-base register incremented by H_RES per row plus column offset; no multiplier.
REQ-027 After the write of pixel (x_end-1, y_end-1) completes, PRINT->DONE and mem_wr_en SHALL be 0 the next cycle.
REQ-028 DONE SHALL last exactly one cycle with done_pulse=1, then return to IDLE.
REQ-029 is_printing SHALL be 1 in PRINT and DONE, 0 in IDLE; it rises the cycle after acceptance and falls the cycle after done_pulse.
REQ-030 cmd_valid while busy SHALL be ignored (no capture, no effect on the running command).
REQ-031 A command presented in the IDLE cycle following DONE SHALL be accepted (back-to-back, one idle cycle between commands).

Reset
REQ-032 With reset_n=0 at a rising edge, the block SHALL enter IDLE: cmd_ready=1, mem_wr_en=0, is_printing=0, done_pulse=0, mem_addr=0, mem_wdata=0.
REQ-033 Reset during PRINT SHALL abort the command without done_pulse; remaining pixels SHALL not be written.

Structure
REQ-034 H_RES/V_RES defaults, address width 19, colour width 9 and the state encoding SHALL live in a shared video package.
REQ-035 One sub-module SHALL be used: rect_clip, the combinational clipping of REQ-020/021; the raster counters and FSM stay in the top.

Verification
REQ-036 x=10,y=20,w=3,h=2,color=0x1FF, mem_wait=0 -> addresses 12810,12811,12812,13450,13451,13452 on consecutive cycles, done_pulse once, is_printing high 7 cycles.
REQ-037 Same command with mem_wait=1 for 4 cycles on the 2nd write -> address 12811 and data held 5 cycles, total of 6 writes, no duplicates.
REQ-038 x=638,y=479,w=5,h=4 -> exactly writes 307198, 307199, then done_pulse.
REQ-039 w=0 (and separately x=700) -> no mem_wr_en, done_pulse after 1 cycle, is_printing high 1 cycle.
REQ-040 Second cmd_valid during PRINT -> ignored; next command after done accepted with one IDLE cycle gap.
REQ-041 reset_n=0 after 2nd write of a 4x4 rectangle -> next cycle mem_wr_en=0, is_printing=0, cmd_ready=1, no done_pulse.
